// File: rtl/alg_boot_pkg.sv
// Shared definitions for the MAC accumulator: FSM state encoding and the
// saturating beat-count width/limit.
package alg_boot_pkg;

    // IDLE: no group open, acc = 0. ACCUM: group open. HOLD: result held.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } mac_state_e;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    // Beat counter increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder with overflow detect.
// Optional clamp on overflow when MAC_ACCUM_SAT_EN is defined; otherwise the
// sum wraps modulo 2^W. The overflow flag is the same in both builds.
module sat_add
    import alg_boot_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W-1:0] raw;

    // Overflow: both operands share a sign and the raw sum has the other sign.
    always_comb begin
        raw   = a_i + b_i;
        ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
`ifdef MAC_ACCUM_SAT_EN
        if (ovf_o) begin
            // Operands were negative -> clamp to most negative, else most positive.
            sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum_o = raw;
        end
`else
        sum_o = raw;
`endif
    end

endmodule

// File: rtl/mac_accum.sv
// Group accumulator for signed Booth-multiplier products.
// Sums beats of a group, counts them (saturating at 255), tracks a sticky
// signed-overflow flag and presents the group result with a valid/ready pair.
// Build option: MAC_ACCUM_SAT_EN clamps overflowing adds instead of wrapping.
//
// Handshake: a beat transfers on a rising clk edge with in_valid && in_ready;
// a result transfers on a rising edge with out_valid && out_ready. out_valid
// and the result fields never change while out_valid=1 and out_ready=0.
// in_ready = !out_valid || out_ready, except that non-last beats are always
// accepted: a new group may accumulate behind an unconsumed result, and only
// its closing beat is held off until the old result is taken.
module mac_accum
    import alg_boot_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*SIZE-1:0] in_p,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf,
    output logic [1:0]        dbg_state_o
);

    mac_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_next;

    assign out_valid   = (state_q == ST_HOLD);
    assign in_ready    = !out_valid || out_ready || !in_last;
    assign accept      = in_valid && in_ready;
    assign p_ext       = ACC_W'($signed(in_p));
    assign cnt_next    = cnt_inc(cnt_q);
    assign out_acc     = out_acc_q;
    assign out_cnt     = out_cnt_q;
    assign out_ovf     = out_ovf_q;
    assign dbg_state_o = state_q;

    sat_add #(.W(ACC_W)) u_sat_add (
        .a_i   (acc_q),
        .b_i   (p_ext),
        .sum_o (sum),
        .ovf_o (add_ovf)
    );

    // Next-state and datapath update for accepted beats and result hand-off.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        out_acc_d = out_acc_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;

        if (accept) begin
            if (in_last) begin
                out_acc_d = sum;
                out_cnt_d = cnt_next;
                out_ovf_d = flag_q || add_ovf;
                acc_d     = '0;
                cnt_d     = '0;
                flag_d    = 1'b0;
            end else begin
                acc_d     = sum;
                cnt_d     = cnt_next;
                flag_d    = flag_q || add_ovf;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = in_last ? ST_HOLD : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (accept && in_last) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept && in_last) begin
                    state_d = ST_HOLD;
                end else if (out_ready) begin
                    // A group opened behind the held result stays open.
                    state_d = (accept || (cnt_q != '0)) ? ST_ACCUM : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            out_acc_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            out_acc_q <= out_acc_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum (SIZE=4, ACC_W=12), default or MAC_ACCUM_SAT_EN build.
module tb_mac_accum;

    localparam int SIZE  = 4;
    localparam int ACC_W = 12;
    localparam int EXP_W = ACC_W + 8 + 1;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2*SIZE-1:0] in_p;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [7:0]        out_cnt;
    logic              out_ovf;
    logic [1:0]        dbg_state_o;

    always #5 clk = ~clk;

    mac_accum #(.SIZE(SIZE), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_p        (in_p),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_acc     (out_acc),
        .out_cnt     (out_cnt),
        .out_ovf     (out_ovf),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Queue the expected result and compare it against what the DUT holds now.
    task automatic expect_res(input string name, input int acc, input int cnt, input bit ovf);
        logic [EXP_W-1:0] e;
        exp_q.push_back({12'(acc), 8'(cnt), ovf});
        e = exp_q.pop_front();
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_acc"}, int'($signed(out_acc)), int'($signed(e[EXP_W-1:9])));
        chk({name, "_cnt"}, int'(out_cnt), int'(e[8:1]));
        chk({name, "_ovf"}, int'(out_ovf), int'(e[0]));
    endtask

    // ---------------- driver ----------------
    // Present a beat after a falling edge, wait (bounded) for in_ready,
    // and return 1 time unit after the accepting rising edge.
    task automatic beat(input int v, input bit last);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_p     = 8'(v);
        in_last  = last;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout actual=in_ready0 required=in_ready1 value=%0d", v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    typedef struct {
        int p;
        bit last;
        int e_acc;
        int e_cnt;
        bit e_ovf;
    } vec_t;

`ifdef MAC_ACCUM_SAT_EN
    localparam int POS_OVF_ACC = 2047;
    localparam int NEG_OVF_ACC = -2047;
`else
    localparam int POS_OVF_ACC = -1937;
    localparam int NEG_OVF_ACC = 1921;
`endif

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{5,    1'b0, 0,   0, 1'b0};
        vecs[1] = '{-3,   1'b0, 0,   0, 1'b0};
        vecs[2] = '{10,   1'b1, 12,  3, 1'b0};
        vecs[3] = '{100,  1'b0, 0,   0, 1'b0};
        vecs[4] = '{-100, 1'b0, 0,   0, 1'b0};
        vecs[5] = '{0,    1'b1, 0,   3, 1'b0};
        vecs[6] = '{-56,  1'b1, -56, 1, 1'b0};
        vecs[7] = '{7,    1'b1, 7,   1, 1'b0};  // last beat while prior result is consumed
        vecs[8] = '{-128, 1'b0, 0,   0, 1'b0};
        vecs[9] = '{127,  1'b1, -1,  2, 1'b0};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_p      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_acc", int'($signed(out_acc)), 0);
        chk("rst_cnt", int'(out_cnt), 0);
        chk("rst_ovf", int'(out_ovf), 0);
        chk("rst_state", int'(dbg_state_o), 0);
        @(negedge clk);
        rst = 1'b1;

        // table-driven groups, out_ready held high
        for (int i = 0; i < 10; i++) begin
            beat(vecs[i].p, vecs[i].last);
            if (vecs[i].last) begin
                expect_res($sformatf("vec%0d", i), vecs[i].e_acc, vecs[i].e_cnt, vecs[i].e_ovf);
                chk($sformatf("vec%0d_state", i), int'(dbg_state_o), 2);
            end else begin
                chk($sformatf("vec%0d_nvalid", i), int'(out_valid), 0);
                chk($sformatf("vec%0d_state", i), int'(dbg_state_o), 1);
            end
        end

        // positive overflow: 17 x 127
        for (int i = 0; i < 16; i++) beat(127, 1'b0);
        beat(127, 1'b1);
        expect_res("pos_ovf", POS_OVF_ACC, 17, 1'b1);

        // negative overflow then a small beat: flag must stick
        for (int i = 0; i < 17; i++) beat(-128, 1'b0);
        beat(1, 1'b1);
        expect_res("neg_ovf", NEG_OVF_ACC, 18, 1'b1);

        // count saturates at 255
        for (int i = 0; i < 260; i++) beat(0, 1'b0);
        beat(0, 1'b1);
        expect_res("cnt_sat", 0, 255, 1'b0);

        // let the result drain, then hold out_ready low
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("drain_valid", int'(out_valid), 0);
        out_ready = 1'b0;
        beat(9, 1'b1);
        expect_res("held", 9, 1, 1'b0);
        beat(1, 1'b0);
        beat(2, 1'b0);
        chk("bp_acc_stable", int'($signed(out_acc)), 9);
        chk("bp_state", int'(dbg_state_o), 2);
        @(negedge clk);
        in_valid = 1'b1;
        in_p     = 8'd3;
        in_last  = 1'b1;
        #1;
        chk("bp_ready_low", int'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_still_low", int'(in_ready), 0);
        chk("bp_acc_hold", int'($signed(out_acc)), 9);
        chk("bp_cnt_hold", int'(out_cnt), 1);
        chk("bp_valid_hold", int'(out_valid), 1);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_high", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_res("bp_new", 6, 3, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("bp_consumed", int'(out_valid), 0);
        chk("bp_idle", int'(dbg_state_o), 0);

        // reset mid-group discards partial sum
        beat(1, 1'b0);
        beat(2, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_state", int'(dbg_state_o), 0);
        @(negedge clk);
        rst = 1'b1;
        beat(4, 1'b1);
        expect_res("after_rst", 4, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
